// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcode encodings, widths, FSM state type and result payload
// for the multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU decode).
// The MDU_OP_* encodings are always defined so decoder encodings stay stable.
package mdu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] MDU_OP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MDU_OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MDU_OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MDU_OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MDU_OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MDU_OP_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] MDU_OP_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] MDU_OP_MADD  = 4'd7;
  localparam logic [OP_W-1:0] MDU_OP_MADDU = 4'd8;
  localparam logic [OP_W-1:0] MDU_OP_MSUB  = 4'd9;
  localparam logic [OP_W-1:0] MDU_OP_MSUBU = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Coarse operation class used by the accept logic.
  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_MTHI = 3'd1,
    CLS_MTLO = 3'd2,
    CLS_MUL  = 3'd3,
    CLS_DIV  = 3'd4
  } op_cls_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Map an opcode to its class; accumulate ops fall to CLS_NONE when disabled.
  function automatic op_cls_e op_class(input logic [OP_W-1:0] op);
    op_cls_e cls;
    cls = CLS_NONE;
    case (op)
      MDU_OP_MULT, MDU_OP_MULTU: cls = CLS_MUL;
      MDU_OP_DIV,  MDU_OP_DIVU:  cls = CLS_DIV;
      MDU_OP_MTHI:               cls = CLS_MTHI;
      MDU_OP_MTLO:               cls = CLS_MTLO;
`ifdef MDU_MADD_EN
      MDU_OP_MADD, MDU_OP_MADDU,
      MDU_OP_MSUB, MDU_OP_MSUBU: cls = CLS_MUL;
`endif
      default:                   cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage request and HI/LO/busy response bundle of the MDU.
//   start, op, a, b : request from the execute stage (master drives)
//   busy, hi, lo    : registered status and architectural HI/LO (slave drives)
interface mdu_if;
  import mdu_pkg::*;

  logic            start;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational MDU datapath.
//   op_i          : MDU opcode
//   a_i, b_i      : rs / rt operands
//   hi_i, lo_i    : current HI/LO (accumulator for the MADD family)
//   res_c_o       : 64-bit {hi,lo} result
//   wr_c_o        : result should be committed (0 for divide-by-zero/undefined)
// Optional feature macro: MDU_MADD_EN (accumulate/subtract datapath).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output hilo_t           res_c_o,
  output logic            wr_c_o
);

  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_u;
  logic              div_signed;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   dvd;
  logic [XLEN-1:0]   dvs;
  logic [XLEN-1:0]   quo_u;
  logic [XLEN-1:0]   rem_u;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  // Sign-extended 64-bit operands give the signed product in the low 64 bits.
  assign prod_s = {{XLEN{a_i[XLEN-1]}}, a_i} * {{XLEN{b_i[XLEN-1]}}, b_i};
  assign prod_u = {{XLEN{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};

  // Signed divide runs on magnitudes so -2^31 / -1 never overflows the divider.
  assign div_signed = (op_i == MDU_OP_DIV);
  assign neg_a      = div_signed & a_i[XLEN-1];
  assign neg_b      = div_signed & b_i[XLEN-1];
  assign dvd        = neg_a ? (XLEN'(0) - a_i) : a_i;
  assign dvs        = (b_i == '0) ? XLEN'(1) : (neg_b ? (XLEN'(0) - b_i) : b_i);
  assign quo_u      = dvd / dvs;
  assign rem_u      = dvd % dvs;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quo        = (neg_a ^ neg_b) ? (XLEN'(0) - quo_u) : quo_u;
  assign rem        = neg_a ? (XLEN'(0) - rem_u) : rem_u;

`ifdef MDU_MADD_EN
  logic [2*XLEN-1:0] acc;
  assign acc = {hi_i, lo_i};
`else
  logic unused_acc;
  assign unused_acc = ^{hi_i, lo_i};
`endif

  always_comb begin
    res_c_o = '0;
    wr_c_o  = 1'b0;
    case (op_i)
      MDU_OP_MULT: begin
        res_c_o = hilo_t'(prod_s);
        wr_c_o  = 1'b1;
      end
      MDU_OP_MULTU: begin
        res_c_o = hilo_t'(prod_u);
        wr_c_o  = 1'b1;
      end
      MDU_OP_DIV, MDU_OP_DIVU: begin
        res_c_o = hilo_t'({rem, quo});
        wr_c_o  = (b_i != '0);
      end
`ifdef MDU_MADD_EN
      MDU_OP_MADD: begin
        res_c_o = hilo_t'(acc + prod_s);
        wr_c_o  = 1'b1;
      end
      MDU_OP_MADDU: begin
        res_c_o = hilo_t'(acc + prod_u);
        wr_c_o  = 1'b1;
      end
      MDU_OP_MSUB: begin
        res_c_o = hilo_t'(acc - prod_s);
        wr_c_o  = 1'b1;
      end
      MDU_OP_MSUBU: begin
        res_c_o = hilo_t'(acc - prod_u);
        wr_c_o  = 1'b1;
      end
`endif
      default: begin
        res_c_o = '0;
        wr_c_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit with architectural HI/LO and a latency counter
// driving the registered busy flag used by the hazard unit.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mdu_if.slave (start/op/a/b in; busy/hi/lo out, all registered)
// Parameters: MULT_CYCLES (1..15), DIV_CYCLES (1..15).
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU).
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  hilo_t            pend_q,  pend_d;
  logic             pend_wr_q, pend_wr_d;
  logic [XLEN-1:0]  hi_q,    hi_d;
  logic [XLEN-1:0]  lo_q,    lo_d;
  logic             busy_q,  busy_d;

  hilo_t   arith_res;
  logic    arith_wr;
  op_cls_e cls;
  logic    accept;

  mdu_arith u_arith (
    .op_i    (bus.op),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .res_c_o (arith_res),
    .wr_c_o  (arith_wr)
  );

  // Next state: count down, commit on the last edge, then load any accepted op.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cls       = op_class(bus.op);
    // The completing edge also accepts, so back-to-back ops lose no cycle.
    accept    = bus.start && ((state_q == ST_IDLE) || (cnt_q == CNT_W'(1)));

    if (state_q == ST_RUN) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        if (pend_wr_q) begin
          hi_d = pend_q.hi;
          lo_d = pend_q.lo;
        end
      end
    end

    // A move issued on the completing edge is younger, so it overrides the commit.
    if (accept) begin
      case (cls)
        CLS_MTHI: hi_d = bus.a;
        CLS_MTLO: lo_d = bus.a;
        CLS_MUL: begin
          state_d   = ST_RUN;
          cnt_d     = CNT_W'(MULT_CYCLES);
          pend_d    = arith_res;
          pend_wr_d = arith_wr;
        end
        CLS_DIV: begin
          state_d   = ST_RUN;
          cnt_d     = CNT_W'(DIV_CYCLES);
          pend_d    = arith_res;
          pend_wr_d = arith_wr;
        end
        default: ;
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed bench for mdu with hand-computed HI/LO/busy expectations.
// Build with MDU_MADD_EN defined to exercise the accumulate opcodes.
module tb_mdu;
  import mdu_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mdu_if bus ();

  mdu #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single edge, then return the request lines to idle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick(1);
    bus.start = 1'b0;
    bus.op    = MDU_OP_NONE;
  endtask

  // Expect busy high on n consecutive samples, then low.
  task automatic run_busy(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      tick(1);
    end
    chk({tag, "_done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    chk({tag, "_hi"}, bus.hi, eh);
    chk({tag, "_lo"}, bus.lo, el);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = MDU_OP_NONE;
    bus.a     = '0;
    bus.b     = '0;
    tick(2);
    rst = 1'b0;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk_hilo("reset", 32'h0, 32'h0);

    // MULT -2 * 3
    issue(MDU_OP_MULT, 32'hFFFF_FFFE, 32'd3);
    chk_hilo("mult_pending", 32'h0, 32'h0);
    run_busy("mult", 5);
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // MULTU max * max
    issue(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_busy("multu", 5);
    chk_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    // DIV -7 / 2
    issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_busy("div", 10);
    chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIVU 7 / 0: full latency, no update
    issue(MDU_OP_DIVU, 32'd7, 32'd0);
    run_busy("divz", 10);
    chk_hilo("divz", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // MTHI / MTLO while idle
    issue(MDU_OP_MTHI, 32'h1234_5678, 32'h0);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    chk_hilo("mthi", 32'h1234_5678, 32'hFFFF_FFFD);
    tick(1);
    chk("mthi_busy2", 32'(bus.busy), 32'd0);
    issue(MDU_OP_MTLO, 32'hCAFE_BABE, 32'h0);
    chk_hilo("mtlo", 32'h1234_5678, 32'hCAFE_BABE);

    // Signed overflow case -2^31 / -1
    issue(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy("divovf", 10);
    chk_hilo("divovf", 32'h0, 32'h8000_0000);

    // DIV 7 / -2
    issue(MDU_OP_DIV, 32'd7, 32'hFFFF_FFFE);
    run_busy("divneg", 10);
    chk_hilo("divneg", 32'h1, 32'hFFFF_FFFD);

    // start while busy is ignored; original DIVU 100/7 commits
    issue(MDU_OP_DIVU, 32'd100, 32'd7);
    tick(2);
    issue(MDU_OP_MTHI, 32'h0000_DEAD, 32'h0);
    chk("ign_busy", 32'(bus.busy), 32'd1);
    chk_hilo("ign_mid", 32'h1, 32'hFFFF_FFFD);
    tick(6);
    chk("ign_busy_last", 32'(bus.busy), 32'd1);
    tick(1);
    chk("ign_done", 32'(bus.busy), 32'd0);
    chk_hilo("ign", 32'h2, 32'hE);

    // Back-to-back: MULT 3*4 then MULTU 0x10000^2 on the completing edge
    issue(MDU_OP_MULT, 32'd3, 32'd4);
    tick(4);
    chk("b2b_busy_last", 32'(bus.busy), 32'd1);
    issue(MDU_OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    chk("b2b_busy_new", 32'(bus.busy), 32'd1);
    chk_hilo("b2b_first", 32'h0, 32'hC);
    tick(1);
    run_busy("b2b", 4);
    chk_hilo("b2b_second", 32'h1, 32'h0);

    // Undefined opcode: no effect
    issue(4'hF, 32'd5, 32'd5);
    chk("undef_busy", 32'(bus.busy), 32'd0);
    chk_hilo("undef", 32'h1, 32'h0);

    // Accumulate family
    issue(MDU_OP_MTHI, 32'h0, 32'h0);
    issue(MDU_OP_MTLO, 32'hFFFF_FFFF, 32'h0);
`ifdef MDU_MADD_EN
    issue(MDU_OP_MADDU, 32'd1, 32'd1);
    run_busy("maddu", 5);
    chk_hilo("maddu", 32'h1, 32'h0);
    issue(MDU_OP_MSUB, 32'd2, 32'd3);
    run_busy("msub", 5);
    chk_hilo("msub", 32'h0, 32'hFFFF_FFFA);
`else
    issue(MDU_OP_MADDU, 32'd1, 32'd1);
    chk("maddu_off_busy", 32'(bus.busy), 32'd0);
    chk_hilo("maddu_off", 32'h0, 32'hFFFF_FFFF);
`endif

    // Reset on cycle 3 of a MULT aborts it
    issue(MDU_OP_MTHI, 32'h0000_AAAA, 32'h0);
    issue(MDU_OP_MULT, 32'd5, 32'd5);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk_hilo("rstmid", 32'h0, 32'h0);
    tick(8);
    chk("rstmid_late_busy", 32'(bus.busy), 32'd0);
    chk_hilo("rstmid_late", 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
